// File: rtl/rv32i_instr_encoder.sv
// rv32i_instr_encoder: packs RV32I fields into instruction words and streams them into instruction memory.
module rv32i_instr_encoder #(
  parameter int ADDR_W = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [2:0]        fmt,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        func3,
  input  logic [6:0]        func7,
  input  logic [31:0]       imm,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err_illegal,
  output logic              err_align,
  output logic              err_overflow,
  output logic [ADDR_W:0]   word_count
);
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic we_q, we_d, ill_q, ill_d, al_q, al_d, ov_q, ov_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d, enc;
  logic [ADDR_W:0] acc_q, acc_d, cnt_q, cnt_d;
  logic wr, acc, full, bad_fmt, mis;
  always_comb begin
    case (fmt)
      3'd0: enc = {func7, rs2, rs1, func3, rd, opcode};
      3'd1: enc = {imm[11:0], rs1, func3, rd, opcode};
      3'd2: enc = {imm[11:5], rs2, rs1, func3, imm[4:0], opcode};
      3'd3: enc = {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], opcode};
      3'd4: enc = {imm[31:12], rd, opcode};
      3'd5: enc = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: enc = 32'h0000_0013;
    endcase
  end
  // acc_q counts accepted words so the next address is known even while a write is still pending
  always_comb begin
    bad_fmt = fmt > 3'd5;
    mis = (fmt == 3'd3 || fmt == 3'd5) && imm[0];
    wr = we_q && mem_ready;
    in_ready = state_q == LOAD && (!we_q || mem_ready);
    acc = in_valid && in_ready;
    full = acc_q[ADDR_W];
    state_d = state_q;
    we_d = wr ? 1'b0 : we_q;
    cnt_d = wr ? cnt_q + 1'b1 : cnt_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    acc_d = acc_q;
    ill_d = ill_q;
    al_d = al_q;
    ov_d = ov_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = LOAD;
        acc_d = '0;
        cnt_d = '0;
        ill_d = 1'b0;
        al_d = 1'b0;
        ov_d = 1'b0;
      end
      LOAD: if (acc) begin
        if (full) ov_d = 1'b1;
        else begin
          we_d = 1'b1;
          addr_d = acc_q[ADDR_W-1:0] + ADDR_W'(BASE_ADDR);
          wdata_d = enc;
          acc_d = acc_q + 1'b1;
          ill_d = ill_q | bad_fmt;
          al_d = al_q | mis;
        end
        if (in_last || full) state_d = DRAIN;
      end
      DRAIN: if (!we_q || mem_ready) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      ill_q <= 1'b0;
      al_q <= 1'b0;
      ov_q <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      ill_q <= ill_d;
      al_q <= al_d;
      ov_q <= ov_d;
    end
  end
  assign mem_we = we_q;
  assign mem_addr = addr_q;
  assign mem_wdata = wdata_q;
  assign busy = state_q == LOAD || state_q == DRAIN;
  assign done = state_q == DONE;
  assign err_illegal = ill_q;
  assign err_align = al_q;
  assign err_overflow = ov_q;
  assign word_count = cnt_q;
endmodule

// File: tb/tb_rv32i_instr_encoder.sv
// tb_rv32i_instr_encoder: scoreboard bench with a field-level encoding model and random backpressure.
module tb_rv32i_instr_encoder;
  localparam int AW = 3;
  localparam int CAP = 1 << AW;
  logic clk = 0, reset = 1, start = 0, in_valid = 0, in_last = 0, mem_ready = 1;
  logic [2:0] fmt = 0, func3 = 0;
  logic [6:0] opcode = 0, func7 = 0;
  logic [4:0] rd = 0, rs1 = 0, rs2 = 0;
  logic [31:0] imm = 0, mem_wdata;
  logic in_ready, mem_we, busy, done, err_illegal, err_align, err_overflow;
  logic [AW-1:0] mem_addr;
  logic [AW:0] word_count;
  int total = 0, bad = 0, stall = 0;
  bit rand_rdy = 0;
  logic [31:0] sb_w[$];
  int sb_a[$];
  int m_acc, m_wr;
  bit m_ill, m_al, m_ov;

  rv32i_instr_encoder #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .func3(func3), .func7(func7), .imm(imm), .mem_we(mem_we), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .done(done),
    .err_illegal(err_illegal), .err_align(err_align), .err_overflow(err_overflow),
    .word_count(word_count));

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", n, a, e);
    end
  endtask

  function automatic logic [31:0] ref_enc(input logic [31:0] f, op, d, s1, s2, f3, f7, im);
    logic [31:0] base;
    base = (s1 << 15) | (f3 << 12) | op;
    case (f)
      0: return (f7 << 25) | (s2 << 20) | base | (d << 7);
      1: return ((im & 32'hfff) << 20) | base | (d << 7);
      2: return (((im >> 5) & 32'h7f) << 25) | (s2 << 20) | base | ((im & 32'h1f) << 7);
      3: return (((im >> 12) & 1) << 31) | (((im >> 5) & 32'h3f) << 25) | (s2 << 20) | base
               | (((im >> 1) & 32'hf) << 8) | (((im >> 11) & 1) << 7);
      4: return (im & 32'hffff_f000) | (d << 7) | op;
      5: return (((im >> 20) & 1) << 31) | (((im >> 1) & 32'h3ff) << 21) | (((im >> 11) & 1) << 20)
               | (((im >> 12) & 32'hff) << 12) | (d << 7) | op;
      default: return 32'h0000_0013;
    endcase
  endfunction

  always @(posedge clk) begin
    #1;
    if (stall > 0) begin
      mem_ready = 0;
      stall--;
    end else mem_ready = rand_rdy ? 1'($urandom % 2) : 1'b1;
  end

  always @(negedge clk) if (!reset) begin
    if (mem_we && mem_ready) begin
      if (sb_w.size() == 0) chk("unexpected_write", 1, 0);
      else begin
        chk("wr_addr", 32'(mem_addr), 32'(sb_a.pop_front()));
        chk("wr_data", mem_wdata, sb_w.pop_front());
      end
    end
    if (mem_we && !mem_ready) chk("ready_under_bp", 32'(in_ready), 0);
    if (!busy && in_ready) chk("ready_outside_load", 32'(in_ready), 0);
  end

  task automatic do_start();
    start = 1;
    @(posedge clk); #2;
    start = 0;
    m_acc = 0; m_wr = 0; m_ill = 0; m_al = 0; m_ov = 0;
    @(negedge clk);
    chk("busy_after_start", 32'(busy), 1);
    chk("flags_clear", {err_illegal, err_align, err_overflow}, 0);
    @(posedge clk); #2;
  endtask

  task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d, s1, s2,
                      input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] im,
                      input bit last, input bit xen, input logic [31:0] xw, input bit need_rdy);
    bit got = 0;
    fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2; func3 = f3; func7 = f7; imm = im;
    in_last = last; in_valid = 1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (need_rdy && i == 0) chk("stream_ready", 32'(in_ready), 1);
      got = in_ready;
      @(posedge clk); #2;
    end
    in_valid = 0; in_last = 0;
    if (!got) chk("accept_timeout", 0, 1);
    else if (m_acc == CAP) m_ov = 1;
    else begin
      sb_a.push_back(m_acc % CAP);
      sb_w.push_back(xen ? xw : ref_enc(32'(f), 32'(op), 32'(d), 32'(s1), 32'(s2), 32'(f3), 32'(f7), im));
      m_acc++; m_wr++;
      m_ill |= f > 5;
      m_al |= (f == 3 || f == 5) && im[0];
    end
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    chk("done_seen", 32'(seen), 1);
    chk("word_count", 32'(word_count), 32'(m_wr));
    chk("errors", {err_illegal, err_align, err_overflow}, {m_ill, m_al, m_ov});
    chk("sb_drained", 32'(sb_w.size()), 0);
    @(negedge clk);
    chk("done_one_cycle", {done, busy}, 0);
    @(posedge clk); #2;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2 reset = 0;
    @(negedge clk);
    chk("reset_outs", {mem_we, busy, done, err_illegal, err_align, err_overflow, in_ready}, 0);
    chk("reset_count", 32'(word_count), 0);
    @(posedge clk); #2;
    do_start();
    send(1, 7'h13, 1, 0, 0, 0, 0, 5, 1, 1, 32'h0050_0093, 0);
    @(negedge clk);
    chk("first_we", {mem_we, 1'b0, 3'(mem_addr)}, {1'b1, 1'b0, 3'd0});
    @(posedge clk); #2;
    wait_done();
    do_start();
    send(0, 7'h33, 3, 1, 2, 0, 0, 0, 0, 1, 32'h0020_81B3, 1);
    send(2, 7'h23, 0, 1, 2, 2, 0, 8, 0, 1, 32'h0020_A423, 1);
    send(3, 7'h63, 0, 1, 2, 0, 0, -32'sd8, 0, 1, 32'hFE20_8CE3, 1);
    send(5, 7'h6f, 1, 0, 0, 0, 0, 16, 0, 1, 32'h0100_00EF, 1);
    send(4, 7'h37, 5, 0, 0, 0, 0, 32'h1234_5000, 1, 1, 32'h1234_52B7, 1);
    wait_done();
    do_start();
    send(0, 7'h33, 3, 1, 2, 0, 0, 0, 0, 1, 32'h0020_81B3, 0);
    stall = 3;
    send(2, 7'h23, 0, 1, 2, 2, 0, 8, 0, 1, 32'h0020_A423, 0);
    send(1, 7'h13, 1, 0, 0, 0, 0, 5, 1, 1, 32'h0050_0093, 0);
    wait_done();
    do_start();
    send(6, 7'h33, 3, 1, 2, 0, 0, 0, 0, 1, 32'h0000_0013, 0);
    send(3, 7'h63, 0, 1, 2, 0, 0, 3, 1, 0, 0, 0);
    wait_done();
    chk("illegal_align_set", {err_illegal, err_align}, 2'b11);
    do_start();
    for (int i = 0; i <= CAP; i++) send(1, 7'h13, 5'(i), 1, 0, 0, 0, i, 0, 0, 0, 0);
    wait_done();
    chk("overflow_set", 32'(err_overflow), 1);
    do_start();
    stall = 100;
    send(1, 7'h13, 2, 0, 0, 0, 0, 7, 0, 0, 0, 0);
    reset = 1;
    @(posedge clk); #2;
    reset = 0; stall = 0;
    sb_w.delete(); sb_a.delete();
    @(negedge clk);
    chk("reset_mid_load", {mem_we, busy, in_ready}, 0);
    @(posedge clk); #2;
    do_start();
    send(1, 7'h13, 1, 0, 0, 0, 0, 5, 1, 1, 32'h0050_0093, 0);
    wait_done();
    rand_rdy = 1;
    for (int p = 0; p < 25; p++) begin
      int len = 1 + $urandom_range(0, 10);
      do_start();
      for (int i = 0; i < len && !m_ov; i++) begin
        int r = $urandom_range(0, 15);
        logic [31:0] im = $urandom;
        send(3'(r < 14 ? r % 6 : 6 + r % 2), 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
             3'($urandom), 7'($urandom), im, i == len - 1, 0, 0, 0);
      end
      wait_done();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rv32i_instr_encoder.md
Name: rv32i_instr_encoder

Overview:
- RV32I instruction encoder and program loader: the write-side counterpart of the instruction decoder.
- Accepts decoded instruction fields (format, opcode, register indices, func3/func7, immediate) over a valid/ready handshake.
- Packs each set of fields into a 32-bit instruction word.
- Writes the words to consecutive word addresses of instruction memory through a single registered write stage with backpressure.
- Used by the boot/test loader to build programs that the fetch/decode path later reads back.

Parameters:
- ADDR_W, 8: instruction-memory word-address width. Capacity is 2^ADDR_W words.
- BASE_ADDR, 0: first word address written after start.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  pulse: begin a new program load at BASE_ADDR
- in_valid  in  1  field set valid
- in_ready  out  1  encoder accepts the field set this cycle
- in_last  in  1  this field set is the final instruction of the program
- fmt  in  3  0=R 1=I 2=S 3=B 4=U 5=J; 6,7 are illegal
- opcode  in  7  opcode
- rd  in  5  destination register
- rs1  in  5  source register 1
- rs2  in  5  source register 2
- func3  in  3  func3
- func7  in  7  func7
- imm  in  32  signed immediate, byte offset for B/J
- mem_we  out  1  write strobe; write occurs when mem_we && mem_ready
- mem_ready  in  1  memory accepts the write
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  32  encoded instruction
- busy  out  1  state is LOAD or DRAIN
- done  out  1  one-cycle pulse when a load finishes
- err_illegal  out  1  sticky: an illegal fmt was seen
- err_align  out  1  sticky: a B/J imm had bit0=1
- err_overflow  out  1  sticky: capacity exceeded
- word_count  out  ADDR_W+1  words written in the current load

Behaviour:
- Clocking and reset: one clock domain, clk. reset is synchronous and active-high. reset clears every output to 0, sets state to IDLE and empties the write stage. Reset mid-load abandons the load; no further writes occur.
- FSM states: IDLE, LOAD, DRAIN, DONE.
- IDLE:
  - in_ready=0.
  - start -> LOAD. The transition clears the address to BASE_ADDR, clears word_count and clears all three error flags.
- LOAD:
  - in_ready = !mem_we || mem_ready.
  - Handshake: accept occurs when in_valid && in_ready. On accept, the encoded word and the current address load into the write stage and mem_we=1 on the next cycle. Latency is 1 cycle from accept to mem_we.
  - Write stage holds mem_addr, mem_wdata and mem_we stable until mem_ready.
  - Each completed write increments the address and word_count.
  - Accept with in_last=1 -> DRAIN.
- DRAIN:
  - in_ready=0.
  - Waits for the pending write to complete, then -> DONE.
- DONE:
  - done=1 for exactly 1 cycle, then -> IDLE.
- start outside IDLE is ignored.
- Encoding, with f7=func7, f3=func3, op=opcode:
  - R: {f7,rs2,rs1,f3,rd,op}
  - I: {imm[11:0],rs1,f3,rd,op}
  - S: {imm[11:5],rs2,rs1,f3,imm[4:0],op}
  - B: {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}
  - U: {imm[31:12],rd,op}
  - J: {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}
  - Upper imm bits beyond each field are dropped silently.
- Illegal fmt: the word written is 32'h00000013 (NOP) and err_illegal is set.
- B/J with imm[0]=1: encoded normally (bit0 is discarded) and err_align is set.
- Overflow: an accept when word_count==2^ADDR_W sets err_overflow and the word is not written. The FSM goes to DRAIN, then DONE, with done pulsing. The address wraps only internally and is never written past capacity.
- Simultaneous write completion and new accept in the same cycle: both take effect. The stage reloads with no bubble, giving full throughput of 1 word/cycle when mem_ready=1.
- Error flags persist through DONE and IDLE until the next start or reset.

Test Plan:
- Reset, then start; I-fmt op=0010011, rd=1, rs1=0, f3=0, imm=5, in_last=1 -> next cycle mem_we=1, addr=0, wdata=0x00500093; done pulses; word_count=1.
- Back-to-back stream with mem_ready=1, no gaps:
  - R add x3,x1,x2 -> 0x002081B3 at addr 0
  - S sw x2,8(x1) -> 0x0020A423 at addr 1
  - B beq x1,x2,-8 -> 0xFE208CE3 at addr 2
  - J jal x1,16 -> 0x010000EF at addr 3
  - U lui x5,0x12345 (imm=0x12345000) -> 0x123452B7 at addr 4
  - in_ready stays 1 throughout.
- Backpressure: hold mem_ready=0 for 3 cycles mid-stream -> in_ready=0, addr/wdata stable, no lost or duplicated word, count correct.
- fmt=6 -> wdata=0x00000013 and err_illegal=1. B with imm=3 -> err_align=1. Next start clears both flags.
- ADDR_W=2 build: write 5 words without in_last -> 4 words written at addr 0-3, err_overflow=1, done pulses, no 5th write.
- Assert reset during LOAD with a write pending -> mem_we=0 next cycle, state IDLE, a subsequent start works from BASE_ADDR.
